control_unit: RTL and testbench



---
 rtl/control_unit.sv | 86 ++++++++
 tb/tb_control_unit.sv | 113 +++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: opcode-driven control sequencer for the hmc-6502 core.
// Alternates a fetch cycle (latch opcode) with that opcode's micro-steps.
//
// Ports:
//   ph1      in   1  clock, all state updates on its rising edge
//   reset    in   1  synchronous active-high reset
//   data_in  in   8  opcode byte, sampled only in fetch cycles
//   controls out  4  control word for the current cycle
module control_unit (
    input  logic       ph1,
    input  logic       reset,
    input  logic [7:0] data_in,
    output logic [3:0] controls
);

    // op_en_reg = 1 marks a fetch cycle
    logic       op_en_reg;
    logic [7:0] opcode;
    logic [1:0] step;

    logic       op_en_next;
    logic [7:0] opcode_next;
    logic [1:0] step_next;
    logic [1:0] last_step;
    logic [3:0] rom_word;

    always_ff @(posedge ph1) begin
        if (reset) begin
            op_en_reg <= 1'b1;
            opcode    <= 8'h00;
            step      <= 2'd0;
        end else begin
            op_en_reg <= op_en_next;
            opcode    <= opcode_next;
            step      <= step_next;
        end
    end

    // Index of the final micro-step; unknown opcodes behave as 0x00
    always_comb begin
        last_step = 2'd0;
        case (opcode)
            8'h01:   last_step = 2'd2;
            8'h02:   last_step = 2'd1;
            8'h03:   last_step = 2'd3;
            default: last_step = 2'd0;
        endcase
    end

    // Micro-sequence ROM; unreachable steps read as 0000
    always_comb begin
        rom_word = 4'b0000;
        case ({opcode, step})
            {8'h01, 2'd0}: rom_word = 4'b0001;
            {8'h01, 2'd1}: rom_word = 4'b0010;
            {8'h01, 2'd2}: rom_word = 4'b0100;
            {8'h02, 2'd0}: rom_word = 4'b1000;
            {8'h02, 2'd1}: rom_word = 4'b1100;
            {8'h03, 2'd0}: rom_word = 4'b0011;
            {8'h03, 2'd1}: rom_word = 4'b0110;
            {8'h03, 2'd2}: rom_word = 4'b1100;
            {8'h03, 2'd3}: rom_word = 4'b1001;
            default:       rom_word = 4'b0000;
        endcase
    end

    always_comb begin
        op_en_next  = op_en_reg;
        opcode_next = opcode;
        step_next   = step;
        if (op_en_reg) begin
            opcode_next = data_in;
            step_next   = 2'd0;
            op_en_next  = 1'b0;
        end else if (step == last_step) begin
            op_en_next = 1'b1;
            step_next  = 2'd0;
        end else begin
            step_next = step + 2'd1;
        end
    end

    // Driven only from registered state, so data_in never reaches controls
    assign controls = op_en_reg ? 4'b0000 : rom_word;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed-vector self-checking bench for control_unit.
// Each step applies data_in, takes one ph1 edge, then checks the new cycle.
module tb_control_unit;

    logic       ph1;
    logic       reset;
    logic [7:0] data_in;
    logic [3:0] controls;

    int total;
    int bad;

    control_unit dut (
        .ph1      (ph1),
        .reset    (reset),
        .data_in  (data_in),
        .controls (controls)
    );

    initial ph1 = 1'b0;
    always #5 ph1 = ~ph1;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge ph1);
        #1;
    endtask

    // Apply din for the current cycle, advance one edge, check the result
    task automatic run(input string tag, input logic [7:0] din,
                       input logic [3:0] exp_c, input logic exp_op);
        data_in = din;
        tick();
        check({tag, ".ctl"}, {4'h0, controls}, {4'h0, exp_c});
        check({tag, ".op"}, {7'h0, dut.op_en_reg}, {7'h0, exp_op});
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        data_in = 8'h5A;
        repeat (5) tick();
        check("rst.ctl", {4'h0, controls}, 8'h00);
        check("rst.op", {7'h0, dut.op_en_reg}, 8'h01);
        check("rst.opc", dut.opcode, 8'h00);
        reset = 1'b0;

        // opcode 0x01 then 0x02
        run("o1s0", 8'h01, 4'b0001, 1'b0);
        check("o1.opc", dut.opcode, 8'h01);
        run("o1s1", 8'h00, 4'b0010, 1'b0);
        run("o1s2", 8'h00, 4'b0100, 1'b0);
        run("o1f", 8'h00, 4'b0000, 1'b1);
        run("o2s0", 8'h02, 4'b1000, 1'b0);
        check("o2.opc", dut.opcode, 8'h02);
        run("o2s1", 8'h00, 4'b1100, 1'b0);
        run("o2f", 8'h00, 4'b0000, 1'b1);

        // opcode 0x03 with data_in toggling during execute
        run("o3s0", 8'h03, 4'b0011, 1'b0);
        data_in = 8'h01;
        #1;
        check("o3.comb", {4'h0, controls}, 8'h03);
        run("o3s1", 8'hAA, 4'b0110, 1'b0);
        run("o3s2", 8'h55, 4'b1100, 1'b0);
        run("o3s3", 8'hFF, 4'b1001, 1'b0);
        check("o3.opc", dut.opcode, 8'h03);
        run("o3f", 8'h02, 4'b0000, 1'b1);

        // illegal opcode decodes as 0x00
        run("ffs0", 8'hFF, 4'b0000, 1'b0);
        check("ff.opc", dut.opcode, 8'hFF);
        run("fff", 8'h00, 4'b0000, 1'b1);

        // reset during step 1 of 0x03
        run("r3s0", 8'h03, 4'b0011, 1'b0);
        run("r3s1", 8'h00, 4'b0110, 1'b0);
        reset = 1'b1;
        tick();
        check("mrst.ctl", {4'h0, controls}, 8'h00);
        check("mrst.op", {7'h0, dut.op_en_reg}, 8'h01);
        check("mrst.opc", dut.opcode, 8'h00);
        reset = 1'b0;

        // back-to-back 0x00
        run("z0", 8'h00, 4'b0000, 1'b0);
        run("z1", 8'h00, 4'b0000, 1'b1);
        run("z2", 8'h00, 4'b0000, 1'b0);
        run("z3", 8'h00, 4'b0000, 1'b1);

        // fetch after back-to-back run still starts a sequence
        run("l1s0", 8'h01, 4'b0001, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
